// File: rtl/i2s_tx_scheduler.sv
// Transmit-side I2S controller: picks one stereo pair per frame from two sources and
// serializes it left-justified, MSB-first, with sclk/lrclk derived from clk.
module i2s_tx_scheduler #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SCLK_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic                  src0_valid,
    input  logic [DATA_WIDTH-1:0] src0_left,
    input  logic [DATA_WIDTH-1:0] src0_right,
    output logic                  src0_ready,
    input  logic                  src1_valid,
    input  logic [DATA_WIDTH-1:0] src1_left,
    input  logic [DATA_WIDTH-1:0] src1_right,
    output logic                  src1_ready,
    output logic                  sclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic                  frame_start,
    output logic [7:0]            underrun_cnt,
    output logic                  busy
);

    localparam int unsigned FrameBits = 2 * DATA_WIDTH;
    localparam int unsigned DivW      = $clog2(SCLK_DIV);
    localparam int unsigned BitW      = $clog2(FrameBits);
    localparam int unsigned SclkHigh  = SCLK_DIV / 2;

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e                 state_q;
    logic [DivW-1:0]        div_q;
    logic [BitW-1:0]        bit_q;
    logic [FrameBits-1:0]   shreg_q;
    logic                   sclk_q;
    logic                   lrclk_q;
    logic                   sdata_q;
    logic                   fs_q;
    logic [7:0]             under_q;

    logic                   bit_tick;
    logic                   last_bit;
    logic                   handshake;
    logic                   pick0;
    logic                   pick1;
    logic                   pick_valid;
    logic                   underrun;
    logic [FrameBits-1:0]   load_pair;

    assign bit_tick  = (state_q == StRun) && (div_q == DivW'(SCLK_DIV - 1));
    assign last_bit  = (bit_q == BitW'(FrameBits - 1));
    // Handshake happens in LOAD, or back-to-back at the final bit of a running frame.
    assign handshake = (state_q == StLoad) || (bit_tick && last_bit && enable);

    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        case (mode)
            2'b01:   pick0 = 1'b1;
            2'b10:   pick1 = 1'b1;
            2'b11: begin
                pick0 = src0_valid;
                pick1 = ~src0_valid;
            end
            default: ;
        endcase
        pick_valid = (pick0 & src0_valid) | (pick1 & src1_valid);
        load_pair  = '0;
        if (pick0 && src0_valid) begin
            load_pair = {src0_left, src0_right};
        end else if (pick1 && src1_valid) begin
            load_pair = {src1_left, src1_right};
        end
        underrun = (mode != 2'b00) && !pick_valid;
    end

    assign src0_ready   = handshake & pick0;
    assign src1_ready   = handshake & pick1;
    assign sclk         = sclk_q;
    assign lrclk        = lrclk_q;
    assign sdata        = sdata_q;
    assign frame_start  = fs_q;
    assign underrun_cnt = under_q;
    assign busy         = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
            fs_q    <= 1'b0;
            under_q <= '0;
        end else begin
            fs_q <= 1'b0;
            if (handshake) begin
                state_q <= StRun;
                div_q   <= '0;
                bit_q   <= '0;
                shreg_q <= load_pair;
                sclk_q  <= 1'b0;
                lrclk_q <= 1'b0;
                sdata_q <= load_pair[FrameBits-1];
                fs_q    <= 1'b1;
                if (underrun && under_q != 8'hFF) begin
                    under_q <= under_q + 8'd1;
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        if (enable) begin
                            state_q <= StLoad;
                        end
                    end
                    StRun: begin
                        if (bit_tick) begin
                            div_q  <= '0;
                            sclk_q <= 1'b0;
                            if (last_bit) begin
                                state_q <= StIdle;
                                bit_q   <= '0;
                                lrclk_q <= 1'b0;
                                sdata_q <= 1'b0;
                            end else begin
                                bit_q   <= bit_q + 1'b1;
                                shreg_q <= shreg_q << 1;
                                sdata_q <= shreg_q[FrameBits-2];
                                lrclk_q <= (32'(bit_q) + 32'd1) >= DATA_WIDTH;
                            end
                        end else begin
                            div_q  <= div_q + 1'b1;
                            sclk_q <= (32'(div_q) + 32'd1) >= SclkHigh;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
